// File: rtl/dqn_cu_pkg.sv
// Shared definitions for the DQN sequencing controller.
//   cu_state_e : controller FSM states (IDLE / RUN / DONE)
//   REASON_*   : episode-end reason codes reported on ep_reason
//   cu_width() : bits needed to hold the values 0..max_val
package dqn_cu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cu_state_e;

  localparam logic [1:0] REASON_NONE    = 2'd0;
  localparam logic [1:0] REASON_TIMEOUT = 2'd1;
  localparam logic [1:0] REASON_GOAL    = 2'd2;
  localparam logic [1:0] REASON_TERM    = 2'd3;

  function automatic int cu_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cu_wrap_cnt.sv
// Wrapping counter used for the phase and step fields.
// Counts 1..LIMIT and wraps back to 1; 0 means "not running".
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear to 0 (highest priority)
//   set_one    : synchronous load of 1 (start of a run / new episode)
//   en         : advance by one, wrapping LIMIT -> 1
//   cnt        : current count
module cu_wrap_cnt #(
  parameter int LIMIT = 9,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         set_one,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (set_one) begin
      cnt_d = W'(1);
    end else if (en) begin
      // >= rather than == so a corrupted value can never run past LIMIT.
      cnt_d = (cnt_q >= W'(LIMIT)) ? W'(1) : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dqn_seq_ctrl.sv
// Sequencing controller for the DQN accelerator.
// Generates the per-step phase count, tracks the step inside an episode and
// the number of completed episodes, and reports why each episode ended.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   start       : level-sampled; starts a run from IDLE or DONE
//   abort       : synchronous return to IDLE, beats every other event
//   stall       : freezes counters and FSM while in RUN
//   st1, term   : next-state and terminal flag, used on the step-end cycle
//   controller  : phase 1..PHASES (0 when not running)
//   step        : step 1..MAX_STEPS (0 when not running)
//   episode     : completed episodes in the current run
//   busy / done : FSM in RUN / in DONE (together they expose the FSM state)
//   step_end    : combinational, last phase of an unstalled, unaborted step
//   ep_end      : one-cycle pulse after the edge that ended an episode
//   ep_reason   : reason for the last episode end (none/timeout/goal/term)
// Control semantics: there is no valid/ready handshake. start, abort, stall,
// st1 and term are plain levels sampled on every rising edge; st1 and term
// only matter on a cycle where step_end is high.
module dqn_seq_ctrl
  import dqn_cu_pkg::*;
#(
  parameter  int PHASES       = 9,
  parameter  int MAX_STEPS    = 15,
  parameter  int STATE_W      = 4,
  parameter  int GOAL_STATE   = 9,
  parameter  int EP_W         = 12,
  parameter  int MAX_EPISODES = 0,
  localparam int PH_W         = cu_width(PHASES),
  localparam int SW           = cu_width(MAX_STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  input  logic [STATE_W-1:0] st1,
  input  logic               term,
  output logic [PH_W-1:0]    controller,
  output logic [SW-1:0]      step,
  output logic [EP_W-1:0]    episode,
  output logic               busy,
  output logic               done,
  output logic               step_end,
  output logic               ep_end,
  output logic [1:0]         ep_reason
);

  cu_state_e       state_q, state_d;
  logic [EP_W-1:0] episode_q, episode_d;
  logic [1:0]      reason_q, reason_d;
  logic            ep_end_q, ep_end_d;

  logic [PH_W-1:0] ctrl_cnt;
  logic [SW-1:0]   step_cnt;

  logic            run, go, adv, hit_goal, ep_cond, fin;
  logic [EP_W-1:0] ep_inc;

  always_comb begin
    run      = (state_q == ST_RUN);
    // A (re)start is possible from IDLE or DONE; abort wins over start.
    go       = start && !abort && !run;
    adv      = run && !stall && !abort;
    step_end = adv && (ctrl_cnt == PH_W'(PHASES));
    hit_goal = (st1 == STATE_W'(GOAL_STATE));
    ep_cond  = step_end && (hit_goal || term || (step_cnt == SW'(MAX_STEPS)));
    ep_inc   = episode_q + EP_W'(1);
    // MAX_EPISODES == 0 means an endless run with a wrapping episode count.
    fin      = ep_cond && (MAX_EPISODES != 0) && (ep_inc == EP_W'(MAX_EPISODES));
  end

  always_comb begin
    state_d   = state_q;
    episode_d = episode_q;
    reason_d  = reason_q;
    ep_end_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d   = ST_RUN;
          episode_d = '0;
          reason_d  = REASON_NONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ep_cond) begin
          episode_d = ep_inc;
          ep_end_d  = 1'b1;
          if (hit_goal)  reason_d = REASON_GOAL;
          else if (term) reason_d = REASON_TERM;
          else           reason_d = REASON_TIMEOUT;
          if (fin) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      episode_q <= '0;
      reason_q  <= REASON_NONE;
      ep_end_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      episode_q <= episode_d;
      reason_q  <= reason_d;
      ep_end_q  <= ep_end_d;
    end
  end

  // Phase counter: runs every unstalled RUN cycle, wrapping PHASES -> 1.
  cu_wrap_cnt #(.LIMIT(PHASES), .W(PH_W)) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (abort || fin),
    .set_one (go),
    .en      (adv),
    .cnt     (ctrl_cnt)
  );

  // Step counter: advances on a step end, restarts at 1 on an episode end.
  cu_wrap_cnt #(.LIMIT(MAX_STEPS), .W(SW)) u_step_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (abort || fin),
    .set_one (go || ep_cond),
    .en      (step_end && !ep_cond),
    .cnt     (step_cnt)
  );

  assign controller = ctrl_cnt;
  assign step       = step_cnt;
  assign episode    = episode_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign ep_end     = ep_end_q;
  assign ep_reason  = reason_q;

endmodule

// File: tb/tb_dqn_seq_ctrl.sv
// Bench for dqn_seq_ctrl with three parameter sets side by side:
//   u0 defaults, u1 finite run (PHASES=3, MAX_STEPS=2, MAX_EPISODES=2),
//   u2 episode wrap (PHASES=2, MAX_STEPS=1, EP_W=2).
module tb_dqn_seq_ctrl;

  localparam int NI = 3;

  int p_ph[NI]  = '{9, 3, 2};
  int p_ms[NI]  = '{15, 2, 1};
  int p_me[NI]  = '{0, 2, 0};
  int p_epw[NI] = '{12, 12, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_i[NI], abort_i[NI], stall_i[NI], term_i[NI];
  logic [3:0] st1_i[NI];

  logic [3:0]  ctrl0, step0;
  logic [11:0] ep0;
  logic        busy0, done0, se0, ee0;
  logic [1:0]  rs0;

  logic [1:0]  ctrl1, step1;
  logic [11:0] ep1;
  logic        busy1, done1, se1, ee1;
  logic [1:0]  rs1;

  logic [1:0]  ctrl2;
  logic [0:0]  step2;
  logic [1:0]  ep2;
  logic        busy2, done2, se2, ee2;
  logic [1:0]  rs2;

  dqn_seq_ctrl u0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .abort(abort_i[0]), .stall(stall_i[0]),
    .st1(st1_i[0]), .term(term_i[0]), .controller(ctrl0), .step(step0), .episode(ep0),
    .busy(busy0), .done(done0), .step_end(se0), .ep_end(ee0), .ep_reason(rs0)
  );

  dqn_seq_ctrl #(.PHASES(3), .MAX_STEPS(2), .MAX_EPISODES(2)) u1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .abort(abort_i[1]), .stall(stall_i[1]),
    .st1(st1_i[1]), .term(term_i[1]), .controller(ctrl1), .step(step1), .episode(ep1),
    .busy(busy1), .done(done1), .step_end(se1), .ep_end(ee1), .ep_reason(rs1)
  );

  dqn_seq_ctrl #(.PHASES(2), .MAX_STEPS(1), .EP_W(2), .MAX_EPISODES(0)) u2 (
    .clk(clk), .rst(rst), .start(start_i[2]), .abort(abort_i[2]), .stall(stall_i[2]),
    .st1(st1_i[2]), .term(term_i[2]), .controller(ctrl2), .step(step2), .episode(ep2),
    .busy(busy2), .done(done2), .step_end(se2), .ep_end(ee2), .ep_reason(rs2)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 finished
  typedef struct {
    int mode; int ph; int st; int ep; int rs; int ee;
  } m_t;

  m_t m[NI];

  function automatic m_t model_next(input int k, input m_t c, input logic go,
                                    input logic ab, input logic sl, input logic tm,
                                    input logic [3:0] s1);
    m_t n;
    n    = c;
    n.ee = 0;
    if (c.mode != 1) begin
      if (ab) n.mode = 0;
      else if (go) begin
        n.mode = 1; n.ph = 1; n.st = 1; n.ep = 0; n.rs = 0;
      end
    end else if (ab) begin
      n.mode = 0; n.ph = 0; n.st = 0;
    end else if (!sl) begin
      if (c.ph < p_ph[k]) begin
        n.ph = c.ph + 1;
      end else begin
        n.ph = 1;
        if (s1 == 4'd9 || tm || c.st == p_ms[k]) begin
          n.ep = (c.ep + 1) % (1 << p_epw[k]);
          n.st = 1;
          n.ee = 1;
          n.rs = (s1 == 4'd9) ? 2 : (tm ? 3 : 1);
          if (p_me[k] != 0 && n.ep == p_me[k]) begin
            n.mode = 2; n.ph = 0; n.st = 0;
          end
        end else begin
          n.st = c.st + 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) m[k] <= '{default: 0};
    end else begin
      for (int k = 0; k < NI; k++)
        m[k] <= model_next(k, m[k], start_i[k], abort_i[k], stall_i[k], term_i[k], st1_i[k]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic [31:0] c, input logic [31:0] s,
                     input logic [31:0] e, input logic [31:0] b, input logic [31:0] d,
                     input logic [31:0] se, input logic [31:0] ee, input logic [31:0] rs);
    int exp_se;
    exp_se = (m[k].mode == 1 && !stall_i[k] && !abort_i[k] && m[k].ph == p_ph[k]) ? 1 : 0;
    chk($sformatf("u%0d.controller", k), c, m[k].ph);
    chk($sformatf("u%0d.step", k), s, m[k].st);
    chk($sformatf("u%0d.episode", k), e, m[k].ep);
    chk($sformatf("u%0d.busy", k), b, (m[k].mode == 1) ? 1 : 0);
    chk($sformatf("u%0d.done", k), d, (m[k].mode == 2) ? 1 : 0);
    chk($sformatf("u%0d.step_end", k), se, exp_se);
    chk($sformatf("u%0d.ep_end", k), ee, m[k].ee);
    chk($sformatf("u%0d.ep_reason", k), rs, m[k].rs);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, ctrl0, step0, ep0, busy0, done0, se0, ee0, rs0);
      cmp(1, ctrl1, step1, ep1, busy1, done1, se1, ee1, rs1);
      cmp(2, ctrl2, step2, ep2, busy2, done2, se2, ee2, rs2);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start_i[k] = 1'b0; abort_i[k] = 1'b0; stall_i[k] = 1'b0;
      term_i[k]  = 1'b0; st1_i[k]   = 4'd1;
      m[k]       = '{default: 0};
    end
    tick(); tick();
    chk_on = 1'b1;
    chk("reset_ctrl", ctrl0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_episode", ep0, 0);
    rst = 1'b1;
    tick();

    // Free run on defaults: first episode times out after 9*15 cycles.
    start_i[0] = 1'b1; tick(); start_i[0] = 1'b0;
    chk("start_ctrl", ctrl0, 1);
    chk("start_busy", busy0, 1);
    n = 0;
    while (!ee0 && n < 300) begin tick(); n++; end
    chk("free_cycles", n, 135);
    chk("free_reason", rs0, 1);
    chk("free_episode", ep0, 1);
    chk("free_step", step0, 1);

    // Goal on step 3's last phase.
    n = 0;
    while (!(ctrl0 == 4'd9 && step0 == 4'd3) && n < 100) begin tick(); n++; end
    chk("goal_wait", n < 100, 1);
    chk("goal_step_end", se0, 1);
    st1_i[0] = 4'd9; tick(); st1_i[0] = 4'd1;
    chk("goal_reason", rs0, 2);
    chk("goal_episode", ep0, 2);
    chk("goal_step", step0, 1);
    chk("goal_ep_end", ee0, 1);

    // Goal and term together: goal wins.
    n = 0;
    while (ctrl0 != 4'd9 && n < 20) begin tick(); n++; end
    st1_i[0] = 4'd9; term_i[0] = 1'b1; tick(); st1_i[0] = 4'd1; term_i[0] = 1'b0;
    chk("goalterm_reason", rs0, 2);
    chk("goalterm_episode", ep0, 3);

    // Term alone.
    n = 0;
    while (ctrl0 != 4'd9 && n < 20) begin tick(); n++; end
    term_i[0] = 1'b1; tick(); term_i[0] = 1'b0;
    chk("term_reason", rs0, 3);

    // Stall for 5 cycles at the last phase of step 1.
    n = 0;
    while (ctrl0 != 4'd9 && n < 20) begin tick(); n++; end
    stall_i[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_step", step0, 1);
      chk("stall_ep_end", ee0, 0);
    end
    stall_i[0] = 1'b0; tick();
    chk("unstall_step", step0, 2);
    chk("unstall_ctrl", ctrl0, 1);

    // Abort on a step end that would have ended the episode.
    n = 0;
    while (ctrl0 != 4'd9 && n < 20) begin tick(); n++; end
    st1_i[0] = 4'd9; abort_i[0] = 1'b1; tick(); st1_i[0] = 4'd1; abort_i[0] = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_ctrl", ctrl0, 0);
    chk("abort_episode", ep0, 4);
    chk("abort_reason", rs0, 3);
    tick();
    chk("abort_no_ep_end", ee0, 0);

    // Finite run: 2 episodes of 2 steps of 3 phases.
    start_i[1] = 1'b1; tick(); start_i[1] = 1'b0;
    n = 0;
    while (!done1 && n < 50) begin tick(); n++; end
    chk("finite_cycles", n, 12);
    chk("finite_episode", ep1, 2);
    chk("finite_ctrl", ctrl1, 0);
    chk("finite_step", step1, 0);
    tick();
    chk("finite_hold_done", done1, 1);
    start_i[1] = 1'b1; tick(); start_i[1] = 1'b0;
    chk("restart_episode", ep1, 0);
    chk("restart_busy", busy1, 1);
    chk("restart_ctrl", ctrl1, 1);

    // Episode counter wrap with a 2-bit field.
    start_i[2] = 1'b1; tick(); start_i[2] = 1'b0;
    n = 0;
    while (ep2 != 2'd3 && n < 40) begin tick(); n++; end
    chk("wrap_reach3", ep2, 3);
    n = 0;
    while (ep2 == 2'd3 && n < 10) begin tick(); n++; end
    chk("wrap_episode", ep2, 0);
    chk("wrap_busy", busy2, 1);
    chk("wrap_ep_end", ee2, 1);

    // Asynchronous reset mid-phase.
    start_i[0] = 1'b1; tick(); start_i[0] = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ctrl", ctrl0, 0);
    chk("arst_step", step0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_episode1", ep1, 0);
    chk("arst_busy2", busy2, 0);
    chk("arst_reason2", rs2, 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
